// File: rtl/gen_rr_arb_pkg.sv
// Shared types and default constants for the round-robin grant-locking arbiter.
package gen_rr_arb_pkg;

   // Arbiter control states: IDLE arbitrates, BUSY holds the current grant.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } gen_rr_arb_st_t;

   // Default requester index width (2**2 = 4 requesters).
   localparam int unsigned REQ_IDX_W_DEF = 2;

   // Default maximum grant hold time, only meaningful with the timeout build.
   localparam int unsigned HOLD_MAX_DEF  = 15;

endpackage : gen_rr_arb_pkg

// File: rtl/gen_dec_top.sv
// Parametric binary-to-one-hot decoder with an enable; all zeros when disabled.
module gen_dec_top #(
   parameter int unsigned DAT_IN_W = 2
) (
   input  logic [DAT_IN_W-1:0]      dat_in,
   input  logic                     en,
   output logic [(2**DAT_IN_W)-1:0] dat_out
);

   // Raise exactly the bit selected by dat_in when enabled.
   always_comb begin
      dat_out = '0;
      for (int i = 0; i < (2**DAT_IN_W); i++) begin
         if (en && (dat_in == DAT_IN_W'(i))) begin
            dat_out[i] = 1'b1;
         end
      end
   end

endmodule : gen_dec_top

// File: rtl/gen_rr_arb_top.sv
// Round-robin arbiter with grant locking. A grant is held until the owner
// pulses done or drops its request. Optional forced release after HOLD_MAX
// busy cycles is enabled by defining GEN_RR_ARB_TIMEOUT_EN (adds the tmo port).
module gen_rr_arb_top
   import gen_rr_arb_pkg::*;
#(
   parameter  int unsigned REQ_IDX_W = REQ_IDX_W_DEF,
   parameter  int unsigned HOLD_MAX  = HOLD_MAX_DEF,
   localparam int unsigned REQ_N     = 2**REQ_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [REQ_N-1:0]     req,
   input  logic                 done,
   output logic                 gnt_vld,
   output logic [REQ_IDX_W-1:0] gnt_idx,
`ifdef GEN_RR_ARB_TIMEOUT_EN
   output logic                 tmo,
`endif
   output logic [REQ_N-1:0]     gnt_oh
);

   gen_rr_arb_st_t       state_q, state_d;
   logic [REQ_IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
   logic [REQ_N-1:0]     req_rot;
   logic [REQ_IDX_W-1:0] ffs_off;
   logic [REQ_IDX_W-1:0] winner;
   logic                 owner_rel;
   logic                 tmo_hit;

   // Rotate req so the pointer position sits at bit 0, find the first set
   // bit, then add the pointer back to recover the absolute winner index.
   always_comb begin
      req_rot = '0;
      for (int i = 0; i < REQ_N; i++) begin
         req_rot[i] = req[ptr_q + REQ_IDX_W'(i)];
      end
      ffs_off = '0;
      for (int i = REQ_N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            ffs_off = REQ_IDX_W'(i);
         end
      end
      winner = ptr_q + ffs_off;
   end

   // Owner-driven release: explicit done or the owner abandoning its request.
   assign owner_rel = done || !req[gnt_idx_q];

`ifdef GEN_RR_ARB_TIMEOUT_EN
   localparam int unsigned HOLD_CNT_W = $clog2(HOLD_MAX + 1);

   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic                  tmo_q, tmo_d;

   // The hold limit is hit on the edge where the incremented count would
   // reach HOLD_MAX, so the grant stays visible for exactly HOLD_MAX cycles.
   assign tmo_hit = (state_q == BUSY) && (hold_cnt_q == HOLD_CNT_W'(HOLD_MAX - 1));

   // Hold counter is zero while idle (so it is clear on entry to BUSY) and
   // counts saturating while busy; tmo flags a release caused only by timeout.
   always_comb begin
      hold_cnt_d = '0;
      tmo_d      = 1'b0;
      if (state_q == BUSY) begin
         hold_cnt_d = (hold_cnt_q == HOLD_CNT_W'(HOLD_MAX)) ? hold_cnt_q
                                                             : hold_cnt_q + HOLD_CNT_W'(1);
         tmo_d      = tmo_hit && !owner_rel;
      end
   end

   // Hold counter and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
         tmo_q      <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         tmo_q      <= tmo_d;
      end
   end

   assign tmo = tmo_q;
`else
   assign tmo_hit = 1'b0;
`endif

   // Next-state logic: arbitrate only in IDLE, lock the grant in BUSY, and
   // move the pointer past the owner on any kind of release.
   always_comb begin
      state_d   = state_q;
      gnt_idx_d = gnt_idx_q;
      ptr_d     = ptr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d   = BUSY;
               gnt_idx_d = winner;
            end
         end
         BUSY: begin
            if (owner_rel || tmo_hit) begin
               state_d   = IDLE;
               gnt_idx_d = '0;
               ptr_d     = gnt_idx_q + REQ_IDX_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, owner and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_idx_q <= '0;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
         ptr_q     <= ptr_d;
      end
   end

   assign gnt_vld = (state_q == BUSY);
   assign gnt_idx = gnt_idx_q;

   gen_dec_top #(
      .DAT_IN_W (REQ_IDX_W)
   ) u_dec (
      .dat_in  (gnt_idx_q),
      .en      (gnt_vld),
      .dat_out (gnt_oh)
   );

endmodule : gen_rr_arb_top

// File: tb/tb_gen_rr_arb_top.sv
// Self-checking bench for gen_rr_arb_top with a behavioural arbitration model.
// Build with GEN_RR_ARB_TIMEOUT_EN defined to exercise the forced-release path.
module tb_gen_rr_arb_top;

   localparam int IDX_W = 2;
   localparam int N     = 4;
   localparam int HMAX  = 4;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic           done;
   logic           gnt_vld;
   logic [IDX_W-1:0] gnt_idx;
   logic [N-1:0]   gnt_oh;
   logic           tmo;

   int n_checks;
   int n_errors;

   // Behavioural model state
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_cycles;
   bit m_tmo;

   gen_rr_arb_top #(
      .REQ_IDX_W (IDX_W),
      .HOLD_MAX  (HMAX)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
`ifdef GEN_RR_ARB_TIMEOUT_EN
      .tmo     (tmo),
`endif
      .gnt_oh  (gnt_oh)
   );

`ifndef GEN_RR_ARB_TIMEOUT_EN
   assign tmo = 1'b0;
`endif

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model: one clock edge of round-robin with grant locking
   task automatic model_edge(input logic [N-1:0] r, input logic d);
      bit rel;
      bit forced;
      m_tmo = 0;
      if (!m_busy) begin
         if (r != 0) begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_ptr + k) % N;
               if (r[c]) begin
                  m_owner = c;
                  break;
               end
            end
            m_busy   = 1;
            m_cycles = 0;
         end
      end else begin
         m_cycles++;
         rel    = d || !r[m_owner];
         forced = 0;
`ifdef GEN_RR_ARB_TIMEOUT_EN
         if (!rel && m_cycles >= HMAX) forced = 1;
`endif
         if (rel || forced) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
            m_tmo  = forced;
         end
      end
   endtask

   task automatic model_reset();
      m_busy   = 0;
      m_owner  = 0;
      m_ptr    = 0;
      m_cycles = 0;
      m_tmo    = 0;
   endtask

   function automatic logic [IDX_W-1:0] exp_idx();
      return m_busy ? IDX_W'(m_owner) : '0;
   endfunction

   function automatic logic [N-1:0] exp_oh();
      return m_busy ? (N'(1) << m_owner) : '0;
   endfunction

   // Advance one clock: inputs already driven at the negedge
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge(req, done);
      @(negedge clk);
   endtask

   task automatic applyReset();
      rst_n = 1'b0;
      req   = '0;
      done  = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      done  = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (gnt_vld !== 1'b0 || gnt_idx !== '0 || gnt_oh !== '0 || tmo !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_outputs: got vld=%b idx=%0d oh=%b tmo=%b expected all zero",
                  gnt_vld, gnt_idx, gnt_oh, tmo);
      end
      req   = '0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      applyReset();
      req = 4'b0100;
      tick();
      n_checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2 || gnt_oh !== 4'b0100) begin
         n_errors++;
         $display("[TB] FAIL single_grant: got vld=%b idx=%0d oh=%b expected vld=1 idx=2 oh=0100",
                  gnt_vld, gnt_idx, gnt_oh);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      n_checks++;
      if (gnt_vld !== 1'b0 || gnt_idx !== '0 || gnt_oh !== '0) begin
         n_errors++;
         $display("[TB] FAIL single_release: got vld=%b idx=%0d oh=%b expected all zero",
                  gnt_vld, gnt_idx, gnt_oh);
      end
      req = 4'b1111;
      tick();
      n_checks++;
      if (gnt_vld !== 1'b1 || gnt_idx !== 2'd3) begin
         n_errors++;
         $display("[TB] FAIL single_ptr3: got vld=%b idx=%0d expected vld=1 idx=3", gnt_vld, gnt_idx);
      end
   endtask

   task automatic test_fairness();
      int order [5] = '{0, 1, 2, 3, 0};
      applyReset();
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         tick();
         n_checks++;
         if (gnt_vld !== 1'b1 || gnt_idx !== IDX_W'(order[g]) || gnt_oh !== (N'(1) << order[g])) begin
            n_errors++;
            $display("[TB] FAIL fair_grant%0d: got vld=%b idx=%0d oh=%b expected vld=1 idx=%0d",
                     g, gnt_vld, gnt_idx, gnt_oh, order[g]);
         end
         done = 1'b1;
         tick();
         done = 1'b0;
         n_checks++;
         if (gnt_vld !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL fair_gap%0d: got vld=%b expected 0", g, gnt_vld);
         end
      end
   endtask

   task automatic test_wrap();
      applyReset();
      req = 4'b1000;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd3 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL wrap_owner3: got vld=%b idx=%0d expected vld=1 idx=3", gnt_vld, gnt_idx);
      end
      req  = 4'b1001;
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd0 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL wrap_to0: got vld=%b idx=%0d expected vld=1 idx=0", gnt_vld, gnt_idx);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd3 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL wrap_then3: got vld=%b idx=%0d expected vld=1 idx=3", gnt_vld, gnt_idx);
      end
   endtask

   task automatic test_abandon();
      applyReset();
      req = 4'b0010;
      tick();
      req = 4'b0000;
      tick();
      n_checks++;
      if (gnt_vld !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL abandon_release: got vld=%b expected 0", gnt_vld);
      end
      req = 4'b1111;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd2 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL abandon_ptr2: got vld=%b idx=%0d expected vld=1 idx=2", gnt_vld, gnt_idx);
      end
      done = 1'b1;
      tick();
      req = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (gnt_vld !== 1'b0 || gnt_oh !== '0) begin
            n_errors++;
            $display("[TB] FAIL idle_done%0d: got vld=%b oh=%b expected 0", c, gnt_vld, gnt_oh);
         end
      end
      done = 1'b0;
      req  = 4'b1111;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd3 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL idle_done_ptr: got vld=%b idx=%0d expected vld=1 idx=3", gnt_vld, gnt_idx);
      end
   endtask

   task automatic test_reset_mid();
      applyReset();
      req = 4'b0100;
      tick();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (gnt_vld !== 1'b0 || gnt_idx !== '0 || gnt_oh !== '0 || tmo !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_mid: got vld=%b idx=%0d oh=%b tmo=%b expected all zero",
                  gnt_vld, gnt_idx, gnt_oh, tmo);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1111;
      tick();
      n_checks++;
      if (gnt_idx !== 2'd0 || gnt_vld !== 1'b1) begin
         n_errors++;
         $display("[TB] FAIL reset_mid_restart: got vld=%b idx=%0d expected vld=1 idx=0", gnt_vld, gnt_idx);
      end
   endtask

   task automatic test_timeout();
      applyReset();
      req = 4'b0011;
      tick();
`ifdef GEN_RR_ARB_TIMEOUT_EN
      begin
         int busy_cycles;
         busy_cycles = 0;
         for (int c = 0; c < 20 && gnt_vld; c++) begin
            busy_cycles++;
            tick();
         end
         n_checks++;
         if (busy_cycles != HMAX || gnt_vld !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL tmo_hold: got %0d busy cycles vld=%b expected %0d cycles then 0",
                     busy_cycles, gnt_vld, HMAX);
         end
         n_checks++;
         if (tmo !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL tmo_pulse: got tmo=%b expected 1", tmo);
         end
         tick();
         n_checks++;
         if (tmo !== 1'b0 || gnt_vld !== 1'b1 || gnt_idx !== 2'd1) begin
            n_errors++;
            $display("[TB] FAIL tmo_next: got tmo=%b vld=%b idx=%0d expected tmo=0 vld=1 idx=1",
                     tmo, gnt_vld, gnt_idx);
         end
      end
`else
      for (int c = 0; c < 100; c++) begin
         tick();
         n_checks++;
         if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0) begin
            n_errors++;
            $display("[TB] FAIL hold_forever%0d: got vld=%b idx=%0d expected vld=1 idx=0",
                     c, gnt_vld, gnt_idx);
         end
      end
`endif
   endtask

   task automatic test_random();
      applyReset();
      for (int c = 0; c < 400; c++) begin
         n_checks++;
         if (gnt_vld !== m_busy || gnt_idx !== exp_idx() || gnt_oh !== exp_oh() || tmo !== m_tmo) begin
            n_errors++;
            $display("[TB] FAIL rand_cycle%0d: got vld=%b idx=%0d oh=%b tmo=%b expected vld=%b idx=%0d oh=%b tmo=%b",
                     c, gnt_vld, gnt_idx, gnt_oh, tmo, m_busy, exp_idx(), exp_oh(), m_tmo);
         end
         if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
         done = ($urandom_range(0, 3) == 0);
         tick();
      end
      done = 1'b0;
   endtask

   // Run all scenarios in sequence, then print the summary
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst_n    = 1'b0;
      req      = '0;
      done     = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_abandon();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_gen_rr_arb_top

// File: doc/gen_rr_arb_top.md
# gen_rr_arb_top

Round-robin arbiter with grant locking, sharing one resource among `2**REQ_IDX_W` requesters. Each grant is held until the owner signals `done` or drops its request. Output is an encoded index plus a one-hot vector; the one-hot vector is produced by the existing parametric decoder. Sits in front of shared datapath resources, e.g. a single memory port or a shared bus.

## Interface
- `REQ_IDX_W`, 2: requester index width [bits].
- `REQ_N`, `2**REQ_IDX_W`: number of requesters (localparam).
- `HOLD_MAX`, 15: maximum grant hold cycles; used only with the timeout feature.
- `HOLD_CNT_W`, `$clog2(HOLD_MAX+1)`: hold counter width (localparam).
- `clk`  input  1  clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `req`  input  REQ_N  request vector; bit i held high by requester i while it wants or owns the resource.
- `done`  input  1  owner releases the resource; sampled only while `gnt_vld`=1.
- `gnt_vld`  output  1  a grant is active.
- `gnt_idx`  output  REQ_IDX_W  index of the current owner; 0 when `gnt_vld`=0.
- `gnt_oh`  output  REQ_N  one-hot owner, all zeros when `gnt_vld`=0.
- `tmo`  output  1  one-cycle pulse on forced release. Present only with `GEN_RR_ARB_TIMEOUT_EN`.

## Operation
- FSM states: `IDLE`, `BUSY`.
- **IDLE**
  - If `|req`=0, stay in `IDLE`.
  - Otherwise, winner = first set bit of `req` scanning `ptr`, `ptr+1`, … with wrap modulo REQ_N.
  - Register `gnt_idx`=winner, `gnt_vld`=1, go to `BUSY`.
- **BUSY**
  - Release condition: `done`=1, or `req[gnt_idx]`=0 (requester abandoned), or a timeout (see Configuration).
  - On release: `gnt_vld`←0, `gnt_idx`←0, `ptr`←`gnt_idx+1` (wraps from REQ_N-1 to 0), go to `IDLE`.
  - Arbitration never occurs in `BUSY`. Changes on other `req` bits are ignored.
- `ptr` is a REQ_IDX_W-bit register, reset to 0. It updates only on release.
- `gnt_oh` = `gen_dec_top(dat_in=gnt_idx, en=gnt_vld)`. It is combinational from registered state, so it carries no extra latency.
- `done` asserted in `IDLE` is ignored.
- Simultaneous `done` and `req[gnt_idx]` drop counts as a single release.

## Timing
- Reset values (async, while `rst_n`=0): `gnt_vld`=0, `gnt_idx`=0, `gnt_oh`=0, `tmo`=0, `ptr`=0, hold count=0, state=`IDLE`.
- Grant latency: a request first sampled at edge N produces `gnt_vld`=1 after edge N.
- Release latency: a release condition sampled at edge M produces `gnt_vld`=0 after edge M.
- Minimum gap between grants is one idle cycle. The next grant is visible after edge M+1.
- Reset asserted mid-grant clears everything immediately. After reset, arbitration restarts from `ptr`=0.

## Configuration
- Macro: `GEN_RR_ARB_TIMEOUT_EN`.
- **Defined**
  - Hold counter clears on entry to `BUSY` and increments each `BUSY` cycle.
  - When the count equals `HOLD_MAX` and no other release condition is present, force a release.
  - `tmo`=1 for the cycle after that edge, i.e. coincident with `gnt_vld` falling.
  - Forced release advances `ptr` exactly like a normal release.
  - The counter saturates and never wraps.
- **Undefined**
  - No counter, no `tmo` port.
  - A grant is held indefinitely until `done` or the request drops.

## Structure
- Package `gen_rr_arb_pkg` holds:
  - `typedef enum logic {IDLE, BUSY} gen_rr_arb_st_t`
  - default parameter constants
- Sub-module: `gen_dec_top` instantiated once, with `DAT_IN_W=REQ_IDX_W`, for `gnt_oh`.
- The priority-from-pointer search is local combinational logic (rotate, find-first-set, un-rotate). It is not a separate module.

## Test plan
- **Single requester:** `REQ_IDX_W`=2, `req`=4'b0100 from reset → `gnt_vld`=1, `gnt_idx`=2, `gnt_oh`=4'b0100 one cycle later. `done` pulse → `gnt_vld`=0 next cycle, `ptr`=3.
- **Fairness, all requesting:** `req`=4'b1111 held, `done` pulsed on each grant → grant order 0,1,2,3,0. Exactly one idle cycle between grants.
- **Wrap:** owner 3 releases with `req`=4'b1001 → next grant is index 0, then index 3 (not 0 again).
- **Abandon:**
  - Owner 1 drops `req[1]` without `done` → release next cycle, `ptr`=2.
  - `done` asserted in `IDLE` → no state change.
- **Reset mid-grant:** `rst_n`=0 during `BUSY` with `gnt_idx`=2 → outputs zero immediately. After release, `req`=4'b1111 grants index 0.
- **Timeout** (macro defined, `HOLD_MAX`=4): owner holds `req` with no `done` → forced release after 4 `BUSY` cycles, `tmo` pulses for 1 cycle, next requester granted. Without the macro, the same stimulus holds the grant for 100 cycles.
